// File: rtl/kgp_pkg.sv
// Shared constants and types for the KGP-RISC stream selector.
// Imported by the selector top and by anything that drives its mode input.
package kgp_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Output buffer occupancy; the encoding is also the word count.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/mux_n_1_stream_if.sv
// Stream bundle between N producers, the selector, and one consumer.
// slave = the selector, master = the producer/consumer side.
interface mux_n_1_stream_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SEL_W = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_src;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_src, out_valid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after 'last', wrapping modulo N.
// The pointer register itself lives in the parent.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_vld
);

  always_comb begin : arb
    int idx;
    idx       = 0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_n_1_stream.sv
// Registered N:1 stream selector: directed or round-robin grant feeding a
// 2-entry in-order output buffer with backpressure.
//
//   state     | meaning
//   ----------+-------------------------------------------
//   BUF_EMPTY | no word buffered, out_valid low
//   BUF_ONE   | one word at head, push and pop both legal
//   BUF_FULL  | two words buffered, no push until a pop
module mux_n_1_stream
  import kgp_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  mux_n_1_stream_if.slave  bus
);

  logic [1:0]       rst_sync;
  logic             active;
  buf_state_e       state, state_nxt;
  logic [WIDTH-1:0] mem_data [2];
  logic [SEL_W-1:0] mem_src  [2];
  logic             hd;
  logic             wr_idx;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_vld;
  logic [SEL_W-1:0] g;
  logic             gv;
  logic             space;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] g_data;

  // Reset asserts asynchronously but grants only open two edges after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign active = rst_n & rst_sync[1];

  rr_arbiter #(.N(N)) u_arb (
    .req       (bus.in_valid),
    .last      (last),
    .grant_idx (rr_idx),
    .grant_vld (rr_vld)
  );

  always_comb begin
    g  = '0;
    gv = 1'b0;
    if (mode == MODE_RR) begin
      g  = rr_idx;
      gv = rr_vld;
    end else begin
      g  = sel;
      gv = ({1'b0, sel} < (SEL_W+1)'(N));
    end
  end

  assign space  = (state != BUF_FULL);
  assign pop    = (state != BUF_EMPTY) & bus.out_ready;
  assign push   = active & space & gv & bus.in_valid[g];
  assign g_data = bus.in_data[g*WIDTH +: WIDTH];
  assign wr_idx = hd ^ (state == BUF_ONE);

  // Directed mode offers ready on sel regardless of that channel's valid.
  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      bus.in_ready[i] = active & space & gv & (g == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BUF_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BUF_EMPTY: if (push) state_nxt = BUF_ONE;
      BUF_ONE: begin
        if (push && !pop)      state_nxt = BUF_FULL;
        else if (!push && pop) state_nxt = BUF_EMPTY;
      end
      BUF_FULL:  if (pop) state_nxt = BUF_ONE;
      default:   state_nxt = BUF_EMPTY;
    endcase
  end

  // Push writes behind the head; push+pop at one word makes the new word the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mem_data[k] <= '0;
        mem_src[k]  <= '0;
      end
      hd   <= 1'b0;
      last <= SEL_W'(N-1);
    end else begin
      if (push) begin
        mem_data[wr_idx] <= g_data;
        mem_src[wr_idx]  <= g;
        if (mode == MODE_RR) last <= g;
      end
      if (pop) hd <= ~hd;
    end
  end

  assign bus.out_data  = mem_data[hd];
  assign bus.out_src   = mem_src[hd];
  assign bus.out_valid = (state != BUF_EMPTY);

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Scoreboard bench for mux_n_1_stream: a queue-level model predicts in_ready
// and the output word order; a separate monitor checks every output beat.
module tb_mux_n_1_stream;
  import kgp_pkg::*;

  localparam int WIDTH = 32;
  localparam int N     = 4;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               src;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic [1:0] sel;

  mux_n_1_stream_if #(.WIDTH(WIDTH), .N(N)) bus ();

  mux_n_1_stream #(.WIDTH(WIDTH), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .sel   (sel),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  exp_t             sb_q[$];
  int               m_last = N-1;
  int               rel_cnt = 0;
  logic [WIDTH-1:0] ch_data [N];
  bit               hold_data = 0;
  bit               last_push = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic void model_grant(output int g, output bit gv);
    g  = 0;
    gv = 0;
    if (mode == MODE_DIRECT) begin
      g  = int'(sel);
      gv = (g < N);
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (!gv && bus.in_valid[i]) begin
          gv = 1;
          g  = i;
        end
      end
    end
  endfunction

  // Called at a falling edge with inputs already chosen; returns at the next falling edge.
  task automatic step();
    int         g;
    bit         gv;
    bit         act;
    logic [N-1:0] exp_rdy;
    bit         push_now;
    for (int i = 0; i < N; i++) bus.in_data[i*WIDTH +: WIDTH] = ch_data[i];
    #1;
    model_grant(g, gv);
    act     = rst_n && (rel_cnt >= 2);
    exp_rdy = '0;
    if (act && gv && sb_q.size() < 2) exp_rdy[g] = 1'b1;
    chk("in_ready", bus.in_ready, exp_rdy);
    push_now  = gv && exp_rdy[g] && bus.in_valid[g];
    last_push = push_now;
    @(posedge clk);
    if (push_now) begin
      sb_q.push_back('{ch_data[g], g});
      if (mode == MODE_RR) m_last = g;
      if (!hold_data) ch_data[g] = $urandom;
    end
    if (rst_n && rel_cnt < 2) rel_cnt++;
    @(negedge clk);
  endtask

  // Monitor: every beat the DUT presents must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      chk("out_valid", bus.out_valid, sb_q.size() > 0);
      if (sb_q.size() > 0 && bus.out_ready === 1'b1) begin
        e = sb_q.pop_front();
        chk("out_data", bus.out_data, e.d);
        chk("out_src", bus.out_src, e.src);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] bp_vals [3];
    int               k;
    bp_vals[0] = 32'hA;
    bp_vals[1] = 32'hB;
    bp_vals[2] = 32'hC;

    rst_n         = 1'b0;
    mode          = MODE_DIRECT;
    sel           = 2'd0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) ch_data[i] = $urandom;
    @(negedge clk);

    // Reset held with inputs toggling
    repeat (5) begin
      mode          = 1'($urandom);
      sel           = 2'($urandom);
      bus.in_valid  = 4'($urandom);
      bus.out_ready = 1'($urandom);
      step();
    end
    rst_n         = 1'b1;
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    repeat (3) step();

    // Directed select of channel 2
    mode         = MODE_DIRECT;
    sel          = 2'd2;
    ch_data[2]   = 32'hDEADBEEF;
    bus.in_valid = 4'b1111;
    step();
    bus.in_valid = '0;
    repeat (2) step();

    // Round-robin with all channels valid
    mode         = MODE_RR;
    bus.in_valid = 4'b1111;
    repeat (8) step();
    bus.in_valid = '0;
    repeat (2) step();

    // Backpressure: channel 1 streams A, B, C while the consumer stalls
    hold_data    = 1;
    mode         = MODE_DIRECT;
    sel          = 2'd1;
    k            = 0;
    ch_data[1]   = bp_vals[0];
    for (int c = 0; c < 10; c++) begin
      bus.out_ready = (c >= 4);
      bus.in_valid  = (k < 3) ? 4'b0010 : 4'b0000;
      step();
      if (last_push) begin
        k++;
        if (k < 3) ch_data[1] = bp_vals[k];
      end
    end
    hold_data = 0;
    ch_data[1] = $urandom;

    // Steady push and pop at one buffered word
    sel           = 2'd0;
    bus.in_valid  = 4'b0001;
    bus.out_ready = 1'b1;
    repeat (6) step();

    // Random traffic with mode/sel changes and random backpressure
    for (int c = 0; c < 300; c++) begin
      mode          = 1'($urandom);
      sel           = 2'($urandom);
      bus.in_valid  = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Fill the buffer, then reset asynchronously between clock edges
    mode          = MODE_RR;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b0;
    repeat (3) step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", bus.out_valid, 1'b0);
    chk("async_rst_in_ready", bus.in_ready, 4'b0000);
    sb_q.delete();
    m_last  = N-1;
    rel_cnt = 0;
    @(negedge clk);
    repeat (2) begin
      bus.in_valid = 4'($urandom);
      step();
    end
    rst_n         = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    repeat (8) step();

    // Drain
    bus.in_valid = '0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
